// File: rtl/pacman_pkg.sv
// Shared pacman game definitions: life FSM state encoding, lives width and default frame counts.
// Used by the collision handler as well as the sprite and score blocks.
package pacman_pkg;

   localparam int unsigned LIVES_W          = 2;
   localparam int unsigned DEF_START_LIVES  = 3;
   localparam int unsigned DEF_DEATH_FRAMES = 60;
   localparam int unsigned DEF_GRACE_FRAMES = 120;

   typedef enum logic [1:0] {
      StPlay     = 2'd0,
      StDying    = 2'd1,
      StGrace    = 2'd2,
      StGameOver = 2'd3
   } state_e;

endpackage

// File: rtl/frame_counter.sv
// Loadable frame down-counter: decrements on frame_tick, holds at zero, load wins over tick.
module frame_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/collision_handler.sv
// Pacman collision handler: edge-detects col and runs the PLAY/DYING/GRACE/GAME_OVER life FSM.
// The respawn immunity window (GRACE, immune output) is built only when COLLISION_GRACE_EN is defined.
module collision_handler
   import pacman_pkg::*;
#(
   parameter int unsigned START_LIVES  = DEF_START_LIVES,
   parameter int unsigned DEATH_FRAMES = DEF_DEATH_FRAMES,
   parameter int unsigned GRACE_FRAMES = DEF_GRACE_FRAMES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               col,
   input  logic               frame_tick,
   input  logic               power_mode,
   input  logic               restart,
   output logic [LIVES_W-1:0] lives,
   output logic               dying,
   output logic               respawn,
   output logic               monster_eaten,
   output logic               game_over,
   output logic               immune
);

   localparam int unsigned MaxFrames = (DEATH_FRAMES > GRACE_FRAMES) ? DEATH_FRAMES : GRACE_FRAMES;
   localparam int unsigned CntW      = $clog2(MaxFrames + 1);

   state_e             state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               col_q, col_event;
   logic               respawn_q, respawn_d;
   logic               eaten_q, eaten_d;
   logic               dying_q, game_over_q;
   logic               cnt_load, cnt_zero;
   logic [CntW-1:0]    cnt_load_val;

   // col_q tracks col in every state so a held overlap never re-fires after respawn.
   assign col_event = col & ~col_q;

   frame_counter #(
      .WIDTH (CntW)
   ) u_frame_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .tick     (frame_tick),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      respawn_d    = 1'b0;
      eaten_d      = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = CntW'(DEATH_FRAMES);
      unique case (state_q)
         StPlay: begin
            if (col_event) begin
               if (power_mode) begin
                  eaten_d = 1'b1;
               end else begin
                  lives_d  = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                  state_d  = StDying;
                  cnt_load = 1'b1;
               end
            end
         end
         StDying: begin
            if (cnt_zero) begin
               if (lives_q == '0) begin
                  state_d = StGameOver;
               end else begin
                  respawn_d = 1'b1;
`ifdef COLLISION_GRACE_EN
                  state_d      = StGrace;
                  cnt_load     = 1'b1;
                  cnt_load_val = CntW'(GRACE_FRAMES);
`else
                  state_d = StPlay;
`endif
               end
            end
         end
`ifdef COLLISION_GRACE_EN
         StGrace: begin
            if (cnt_zero) begin
               state_d = StPlay;
            end
         end
`endif
         StGameOver: begin
            if (restart) begin
               lives_d   = LIVES_W'(START_LIVES);
               respawn_d = 1'b1;
               state_d   = StPlay;
            end
         end
         default: state_d = StPlay;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StPlay;
         lives_q     <= LIVES_W'(START_LIVES);
         col_q       <= 1'b0;
         respawn_q   <= 1'b0;
         eaten_q     <= 1'b0;
         dying_q     <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         col_q       <= col;
         respawn_q   <= respawn_d;
         eaten_q     <= eaten_d;
         dying_q     <= (state_d == StDying);
         game_over_q <= (state_d == StGameOver);
      end
   end

`ifdef COLLISION_GRACE_EN
   logic immune_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         immune_q <= 1'b0;
      end else begin
         immune_q <= (state_d == StGrace);
      end
   end

   assign immune = immune_q;
`else
   assign immune = 1'b0;
`endif

   assign lives         = lives_q;
   assign dying         = dying_q;
   assign respawn       = respawn_q;
   assign monster_eaten = eaten_q;
   assign game_over     = game_over_q;

endmodule

// File: tb/tb_collision_handler.sv
// Self-checking bench for collision_handler: life-cycle model compared every cycle plus
// directed scenarios; grace-window scenarios are compiled in with COLLISION_GRACE_EN.
module tb_collision_handler;

   localparam int START = 3;
   localparam int DEATH = 60;
   localparam int GRACE = 120;
`ifdef COLLISION_GRACE_EN
   localparam bit GraceOn = 1'b1;
`else
   localparam bit GraceOn = 1'b0;
`endif

   localparam int MPlay  = 0;
   localparam int MDying = 1;
   localparam int MGrace = 2;
   localparam int MOver  = 3;

   logic       clk;
   logic       rst_n;
   logic       col;
   logic       frame_tick;
   logic       power_mode;
   logic       restart;
   logic [1:0] lives;
   logic       dying;
   logic       respawn;
   logic       monster_eaten;
   logic       game_over;
   logic       immune;

   int checks = 0;
   int errors = 0;
   int n_resp = 0;
   int n_eat  = 0;
   bit chk_en = 1'b0;

   // Game model: mode, lives, frames left in the current timed phase, last col level.
   int m_mode  = MPlay;
   int m_lives = START;
   int m_timer = 0;
   bit m_prev  = 1'b0;
   bit m_resp  = 1'b0;
   bit m_eat   = 1'b0;

   collision_handler #(
      .START_LIVES  (START),
      .DEATH_FRAMES (DEATH),
      .GRACE_FRAMES (GRACE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .col           (col),
      .frame_tick    (frame_tick),
      .power_mode    (power_mode),
      .restart       (restart),
      .lives         (lives),
      .dying         (dying),
      .respawn       (respawn),
      .monster_eaten (monster_eaten),
      .game_over     (game_over),
      .immune        (immune)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step();
      bit ev;
      ev     = col && !m_prev;
      m_resp = 1'b0;
      m_eat  = 1'b0;
      if (!rst_n) begin
         m_mode  = MPlay;
         m_lives = START;
         m_timer = 0;
         m_prev  = 1'b0;
         return;
      end
      m_prev = col;
      case (m_mode)
         MPlay: begin
            if (ev && power_mode) begin
               m_eat = 1'b1;
            end else if (ev) begin
               m_lives = (m_lives > 0) ? m_lives - 1 : 0;
               m_mode  = MDying;
               m_timer = DEATH;
            end
         end
         MDying, MGrace: begin
            if (m_timer != 0) begin
               if (frame_tick) m_timer = m_timer - 1;
            end else if (m_mode == MGrace) begin
               m_mode = MPlay;
            end else if (m_lives == 0) begin
               m_mode = MOver;
            end else begin
               m_resp = 1'b1;
               m_mode = GraceOn ? MGrace : MPlay;
               m_timer = GRACE;
            end
         end
         default: begin
            if (restart) begin
               m_lives = START;
               m_resp  = 1'b1;
               m_mode  = MPlay;
            end
         end
      endcase
   endtask

   task automatic step(input bit c, input bit t, input bit p, input bit r);
      col        = c;
      frame_tick = t;
      power_mode = p;
      restart    = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (respawn === 1'b1) n_resp++;
      if (monster_eaten === 1'b1) n_eat++;
   endtask

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (lives !== 2'(m_lives) || dying !== (m_mode == MDying) ||
             game_over !== (m_mode == MOver) || immune !== (m_mode == MGrace) ||
             respawn !== m_resp || monster_eaten !== m_eat) begin
            errors++;
            $display("FAIL model_compare @%0t: got lives=%0d dy=%b go=%b im=%b rs=%b me=%b, expected lives=%0d dy=%b go=%b im=%b rs=%b me=%b",
                     $time, lives, dying, game_over, immune, respawn, monster_eaten,
                     m_lives, m_mode == MDying, m_mode == MOver, m_mode == MGrace, m_resp, m_eat);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      col = 1'b0; frame_tick = 1'b0; power_mode = 1'b0; restart = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk_en = 1'b1;
      check_eq("reset_lives", lives, 3);
      check_eq("reset_dying", dying, 0);
      check_eq("reset_game_over", game_over, 0);
      check_eq("reset_respawn", respawn, 0);
      check_eq("reset_immune", immune, 0);
      rst_n = 1'b1;

      step(0, 0, 0, 1);
      check_eq("restart_in_play", lives, 3);

      // First death, then respawn after exactly DEATH ticks.
      step(1, 0, 0, 0);
      check_eq("death1_lives", lives, 2);
      check_eq("death1_dying", dying, 1);
      check_eq("death1_counter", 32'(dut.u_frame_counter.cnt_q), 60);
      n_resp = 0;
      repeat (60) step(0, 1, 0, 0);
      check_eq("death1_last_tick_dying", dying, 1);
      check_eq("death1_no_early_respawn", n_resp, 0);
      step(0, 0, 0, 0);
      check_eq("death1_respawn", respawn, 1);
      check_eq("death1_dying_clear", dying, 0);
      check_eq("death1_immune", immune, 32'(GraceOn));
      step(0, 0, 0, 0);
      check_eq("death1_respawn_once", n_resp, 1);
`ifdef COLLISION_GRACE_EN
      step(1, 0, 0, 0);
      check_eq("grace_event_lives", lives, 2);
      check_eq("grace_event_dying", dying, 0);
      n_eat = 0;
      step(0, 0, 1, 0);
      step(1, 0, 1, 0);
      step(0, 0, 0, 0);
      check_eq("grace_no_eat", n_eat, 0);
      repeat (120) step(0, 1, 0, 0);
      check_eq("grace_last_tick_immune", immune, 1);
      step(0, 0, 0, 0);
      check_eq("grace_end_immune", immune, 0);
`endif

      // Second death with col held high through the whole cycle.
      step(1, 0, 0, 0);
      check_eq("death2_lives", lives, 1);
      repeat (60) step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      check_eq("death2_respawn", respawn, 1);
`ifdef COLLISION_GRACE_EN
      repeat (121) step(1, 1, 0, 0);
`endif
      repeat (5) step(1, 0, 0, 0);
      check_eq("held_col_no_event", lives, 1);
      check_eq("held_col_not_dying", dying, 0);

      // Third death coincident with a frame tick: counter must be loaded untouched.
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      check_eq("death3_lives", lives, 0);
      check_eq("tick_coincident_counter", 32'(dut.u_frame_counter.cnt_q), 60);
      n_resp = 0;
      repeat (60) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      check_eq("over_game_over", game_over, 1);
      check_eq("over_lives", lives, 0);
      n_eat = 0;
      step(1, 0, 0, 0);
      step(0, 1, 1, 0);
      step(1, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);
      check_eq("over_no_respawn", n_resp, 0);
      check_eq("over_no_eat", n_eat, 0);
      check_eq("over_held", game_over, 1);
      step(0, 0, 0, 1);
      check_eq("restart_lives", lives, 3);
      check_eq("restart_respawn", respawn, 1);
      check_eq("restart_game_over", game_over, 0);
      step(0, 0, 0, 0);
      check_eq("restart_respawn_once", n_resp, 1);

      // Sustained powered overlap eats exactly one monster.
      n_eat = 0;
      repeat (500) step(1, 0, 1, 0);
      check_eq("power_one_eat", n_eat, 1);
      check_eq("power_lives", lives, 3);
      step(0, 0, 1, 0);

      // Reset in the middle of DYING aborts without respawn.
      step(1, 0, 0, 0);
      check_eq("abort_dying_lives", lives, 2);
      repeat (30) step(0, 1, 0, 0);
      check_eq("abort_counter_30", 32'(dut.u_frame_counter.cnt_q), 30);
      n_resp = 0;
      rst_n = 1'b0;
      step(0, 1, 0, 0);
      check_eq("abort_lives", lives, 3);
      check_eq("abort_dying", dying, 0);
      check_eq("abort_respawn", respawn, 0);
      rst_n = 1'b1;
      repeat (5) step(0, 1, 0, 0);
      check_eq("abort_no_late_respawn", n_resp, 0);
`ifdef COLLISION_GRACE_EN
      step(1, 0, 0, 0);
      repeat (60) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      repeat (10) step(0, 1, 0, 0);
      check_eq("grace_mid_immune", immune, 1);
      rst_n = 1'b0;
      step(0, 0, 0, 0);
      check_eq("abort_grace_immune", immune, 0);
      check_eq("abort_grace_lives", lives, 3);
      rst_n = 1'b1;
      step(0, 0, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
